btn_conditioner: RTL and testbench

//  Cleans the raw stopwatch push-buttons (ui_in[3:0]) before the control logic uses them.
//  Per button: 2-flop synchroniser, tick-sampled debounce FSM, one-cycle press/release

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_channel.sv | 134 +++++++++++++
 rtl/btn_conditioner.sv | 51 +++++
 tb/tb_btn_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types for the push-button conditioner
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, tick-sampled debounce FSM, edge and long-press pulses
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 10,
  parameter int LONG_CNT   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic sample_tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CNT);
  localparam logic [HW-1:0] LONG_H   = HW'(LONG_CNT);
  localparam logic [HW-1:0] STABLE_H = HW'(STABLE_CNT);

  logic          s1, s2;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  // hold counts from the first agreeing sample, so it starts at STABLE_CNT on press
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (s2) begin
            if (STABLE_CNT == 1) begin
              state_d = HELD;
              level_d = 1'b1;
              press_d = 1'b1;
              hold_d  = STABLE_H;
              cnt_d   = '0;
            end else begin
              state_d = ARM;
              cnt_d   = CW'(1);
            end
          end
        end
        ARM: begin
          if (!s2) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == STABLE_C) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = STABLE_H;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (s2) begin
            if (hold_q != LONG_H) begin
              hold_d = hold_q + HW'(1);
              long_d = (hold_q + HW'(1) == LONG_H);
            end
          end else if (STABLE_CNT == 1) begin
            state_d = IDLE;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            state_d = DISARM;
            cnt_d   = CW'(1);
          end
        end
        DISARM: begin
          if (s2) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == STABLE_C) begin
            state_d = IDLE;
            level_d = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_long    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - shared sample prescaler plus N_BTN independent button channels
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int SAMPLE_DIV = 12000,
  parameter int STABLE_CNT = 10,
  parameter int LONG_CNT   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             sample_tick
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (pcnt == DIV_LAST);
      pcnt        <= (pcnt == DIV_LAST) ? '0 : pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_CNT  (LONG_CNT)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[i]),
      .sample_tick(sample_tick),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench: expected pulse events queued, monitor compares
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       sample_tick;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  lng;
    logic [3:0]  lvl;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_want;
  int  total = 0;
  int  bad = 0;
  int  cyc;

  btn_conditioner #(
    .N_BTN(4), .SAMPLE_DIV(4), .STABLE_CNT(3), .LONG_CNT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  // cycle index since reset release: value k at the negedge after posedge k
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && (btn_press | btn_release | btn_long) != 4'h0) begin
      mon_got = {32'(cyc), btn_press, btn_release, btn_long, btn_level};
      total += 1;
      if (exp_q.size() == 0) begin
        bad += 1;
        $display("FAIL unexpected_pulse: cyc=%0d p=%h r=%h l=%h v=%h, none expected",
                 cyc, btn_press, btn_release, btn_long, btn_level);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          bad += 1;
          $display("FAIL event: got cyc=%0d p=%h r=%h l=%h v=%h, want cyc=%0d p=%h r=%h l=%h v=%h",
                   mon_got.cyc, mon_got.press, mon_got.rel, mon_got.lng, mon_got.lvl,
                   mon_want.cyc, mon_want.press, mon_want.rel, mon_want.lng, mon_want.lvl);
        end
      end
    end
  end

  function automatic ev_t mk(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l, logic [3:0] v);
    return {32'(c), p, r, l, v};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total += 1;
    if (got !== want) begin
      bad += 1;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset(input logic [3:0] raw);
    @(negedge clk);
    rst_n   = 1'b0;
    btn_raw = raw;
    repeat (3) @(negedge clk);
    check("outputs_in_reset",
          32'({btn_level, btn_press, btn_release, btn_long, sample_tick}), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Sample edges of the FSMs are posedges 5, 9, 13, ...; raw set at cycle c is first
  // seen on the first sample edge >= c+3.
  initial begin
    // 1: all buttons held through reset, common press, release 3 ticks after drop
    do_reset(4'hF);
    exp_q.push_back(mk(13, 4'hF, 4'h0, 4'h0, 4'hF));
    exp_q.push_back(mk(25, 4'h0, 4'hF, 4'h0, 4'h0));
    at_cyc(1);
    check("first_cycle_outputs",
          32'({btn_level, btn_press, btn_release, btn_long, sample_tick}), 32'h0);
    for (int c = 2; c <= 8; c++) begin
      at_cyc(c);
      check("sample_tick", 32'(sample_tick), 32'((c % 4) == 0));
    end
    at_cyc(13);
    btn_raw = 4'h0;
    drain("t1_drain");

    // 2: clean long hold on btn0
    do_reset(4'h0);
    exp_q.push_back(mk(13, 4'h1, 4'h0, 4'h0, 4'h1));
    exp_q.push_back(mk(33, 4'h0, 4'h0, 4'h1, 4'h1));
    exp_q.push_back(mk(105, 4'h0, 4'h1, 4'h0, 4'h0));
    at_cyc(1);  btn_raw = 4'h1;
    at_cyc(20); check("t2_level_held", 32'(btn_level), 32'h1);
    at_cyc(93); btn_raw = 4'h0;
    drain("t2_drain");

    // 3: bounce on btn1 never reaches STABLE_CNT
    do_reset(4'h0);
    at_cyc(1);  btn_raw = 4'h2;
    at_cyc(5);  btn_raw = 4'h0;
    at_cyc(9);  btn_raw = 4'h2;
    at_cyc(13); btn_raw = 4'h0;
    at_cyc(45);
    check("t3_level", 32'(btn_level), 32'h0);
    drain("t3_drain");

    // 4: btn2 one-tick release glitch after the long pulse
    do_reset(4'h0);
    exp_q.push_back(mk(13, 4'h4, 4'h0, 4'h0, 4'h4));
    exp_q.push_back(mk(33, 4'h0, 4'h0, 4'h4, 4'h4));
    exp_q.push_back(mk(73, 4'h0, 4'h4, 4'h0, 4'h0));
    at_cyc(1);  btn_raw = 4'h4;
    at_cyc(37); btn_raw = 4'h0;
    at_cyc(41); btn_raw = 4'h4;
    at_cyc(50); check("t4_level_after_glitch", 32'(btn_level), 32'h4);
    at_cyc(61); btn_raw = 4'h0;
    drain("t4_drain");

    // 5: short press on btn3, no long pulse
    do_reset(4'h0);
    exp_q.push_back(mk(13, 4'h8, 4'h0, 4'h0, 4'h8));
    exp_q.push_back(mk(33, 4'h0, 4'h8, 4'h0, 4'h0));
    at_cyc(1);  btn_raw = 4'h8;
    at_cyc(21); btn_raw = 4'h0;
    at_cyc(60);
    drain("t5_drain");

    // 6: async reset while btn0 is mid-ARM and btn1 is held
    do_reset(4'h0);
    exp_q.push_back(mk(13, 4'h2, 4'h0, 4'h0, 4'h2));
    at_cyc(1);  btn_raw = 4'h2;
    at_cyc(13); btn_raw = 4'h3;
    at_cyc(23);
    check("t6_press_seen", 32'(exp_q.size()), 32'h0);
    check("t6_level_before", 32'(btn_level), 32'h2);
    #2 rst_n = 1'b0;
    #1 check("t6_async_clear", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
    btn_raw = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t6_level_after", 32'(btn_level), 32'h0);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
